// File: rtl/lab2_proc_inflight_drop_unit.sv
// rtl/lab2_proc_inflight_drop_unit.sv - bounds outstanding imem requests and discards responses owed to squashes
module lab2_proc_inflight_drop_unit #(
   parameter int p_msg_nbits    = 47,
   parameter int p_max_inflight = 4,
   localparam int c_cnt_nbits   = $clog2(p_max_inflight + 1)
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_val,
   output logic                   req_rdy,
   output logic                   req_down_val,
   input  logic                   req_down_rdy,
   input  logic                   drop,
   input  logic [p_msg_nbits-1:0] istream_msg,
   input  logic                   istream_val,
   output logic                   istream_rdy,
   output logic [p_msg_nbits-1:0] ostream_msg,
   output logic                   ostream_val,
   input  logic                   ostream_rdy,
   output logic [c_cnt_nbits-1:0] num_inflight,
   output logic [c_cnt_nbits-1:0] num_to_drop
);

   localparam logic [c_cnt_nbits-1:0] cnt_max = c_cnt_nbits'(p_max_inflight);
   localparam logic [c_cnt_nbits-1:0] cnt_one = c_cnt_nbits'(1);

   typedef enum logic {PASS, DRAIN} state_t;

   state_t                 state, state_next;
   logic [c_cnt_nbits-1:0] inflight, inflight_next;
   logic [c_cnt_nbits-1:0] drop_cnt, drop_cnt_next;
   logic                   full, req_go, resp_go;

   always_comb begin
      full         = (inflight == cnt_max);
      req_down_val = req_val & ~full & ~reset;
      req_rdy      = req_down_rdy & ~full & ~reset;
      req_go       = req_val & req_rdy;
   end

   // A squash supersedes any pending drain: everything still in flight
   // (minus a response consumed this very cycle) is owed to it.
   always_comb begin
      state_next    = state;
      drop_cnt_next = drop_cnt;
      istream_rdy   = 1'b0;
      ostream_val   = 1'b0;
      if (drop) begin
         istream_rdy   = 1'b1;
         drop_cnt_next = (istream_val && inflight != '0) ? inflight - cnt_one : inflight;
      end else if (state == DRAIN) begin
         istream_rdy = 1'b1;
         if (istream_val && drop_cnt != '0)
            drop_cnt_next = drop_cnt - cnt_one;
      end else begin
         istream_rdy = ostream_rdy;
         ostream_val = istream_val;
      end
      state_next = (drop_cnt_next != '0) ? DRAIN : PASS;
      if (reset) begin
         istream_rdy = 1'b0;
         ostream_val = 1'b0;
      end
   end

   assign resp_go = istream_val & istream_rdy;

   always_comb begin
      inflight_next = inflight;
      if (req_go && !resp_go)
         inflight_next = inflight + cnt_one;
      else if (!req_go && resp_go && inflight != '0)
         inflight_next = inflight - cnt_one;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= PASS;
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         state    <= state_next;
         inflight <= inflight_next;
         drop_cnt <= drop_cnt_next;
      end
   end

   assign ostream_msg  = istream_msg;
   assign num_inflight = inflight;
   assign num_to_drop  = drop_cnt;

   // A response with nothing outstanding means the memory side broke protocol.
   assert property (@(posedge clk) disable iff (reset) !(istream_val && inflight == '0));

endmodule
